// File: rtl/el2_ahb_pkg.sv
// Shared AHB-Lite encodings and bridge state codes for the Wishbone-to-AHB path.
package el2_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADDR = 2'd1;
    localparam state_t ST_DATA = 2'd2;
    localparam state_t ST_ACK  = 2'd3;

endpackage

// File: rtl/wb_sel_decode.sv
// Maps a Wishbone byte-lane select to an AHB transfer size and byte offset.
module wb_sel_decode
    import el2_ahb_pkg::*;
(
    input  logic [3:0] sel,
    output logic       legal,
    output logic [2:0] hsize,
    output logic [1:0] offset
);

    always_comb begin
        legal  = 1'b1;
        hsize  = HSIZE_BYTE;
        offset = 2'd0;
        case (sel)
            4'b1111: hsize = HSIZE_WORD;
            4'b0011: hsize = HSIZE_HALF;
            4'b1100: begin hsize = HSIZE_HALF; offset = 2'd2; end
            4'b0001: offset = 2'd0;
            4'b0010: offset = 2'd1;
            4'b0100: offset = 2'd2;
            4'b1000: offset = 2'd3;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/wb_ahb_bridge.sv
// Wishbone classic slave issuing one AHB-Lite SINGLE transfer per request.
//   state | meaning
//   IDLE  | waiting for stb & cyc
//   ADDR  | AHB address phase, HTRANS = NONSEQ
//   DATA  | AHB data phase, waiting for HREADY
//   ACK   | one-cycle Wishbone acknowledge
module wb_ahb_bridge
    import el2_ahb_pkg::*;
#(
    parameter logic [31:0] AHB_BASE  = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK = 32'h00FF_FFFC
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP,
    output logic        err_o,
    input  logic        err_clr_i
);

    state_t      state_q;
    logic        we_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req;
    logic        sel_legal;
    logic [2:0]  sel_size;
    logic [1:0]  sel_off;
    logic        err_set;

    wb_sel_decode u_sel_decode (
        .sel    (wbs_sel_i),
        .legal  (sel_legal),
        .hsize  (sel_size),
        .offset (sel_off)
    );

    assign req = wbs_stb_i & wbs_cyc_i;

    // An ERROR response only counts on its completing (HREADY high) cycle.
    assign err_set = ((state_q == ST_IDLE) & req & ~sel_legal)
                   | ((state_q == ST_DATA) & HREADY & HRESP);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_q    <= wbs_we_i;
                        size_q  <= sel_size;
                        addr_q  <= (wbs_adr_i & ADDR_MASK) | AHB_BASE | {30'd0, sel_off};
                        wdata_q <= wbs_dat_i;
                        if (sel_legal) begin
                            state_q <= ST_ADDR;
                        end else begin
                            rdata_q <= 32'd0;
                            state_q <= ST_ACK;
                        end
                    end
                end
                ST_ADDR: begin
                    if (HREADY) state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (HREADY) begin
                        if (!we_q) rdata_q <= HRDATA;
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)       err_q <= 1'b0;
        else if (err_set)   err_q <= 1'b1;
        else if (err_clr_i) err_q <= 1'b0;
    end

    // The transfer cannot be aborted, but a master that dropped cyc gets no ack.
    assign wbs_ack_o = (state_q == ST_ACK) & wbs_cyc_i;
    assign wbs_dat_o = rdata_q;
    assign err_o     = err_q;

    assign HTRANS    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = addr_q;
    assign HSIZE     = size_q;
    assign HWRITE    = we_q;
    assign HWDATA    = wdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DEFAULT;
    assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_wb_ahb_bridge.sv
// Scoreboard bench for wb_ahb_bridge: expected AHB transfers queued at request time.
module tb_wb_ahb_bridge;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam logic [31:0] MASK = 32'h00FF_FFFC;

    logic        HCLK, HRESETn;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic        wbs_ack_o;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK, HWRITE, HREADY, HRESP;
    logic        err_o, err_clr_i;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic [2:0]  burst;
        logic [3:0]  prot;
        logic        lock;
    } xfer_t;

    xfer_t exp_q[$];
    xfer_t obs_q[$];
    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_rd = 32'd0;

    wb_ahb_bridge #(.AHB_BASE(BASE), .ADDR_MASK(MASK)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP),
        .err_o(err_o), .err_clr_i(err_clr_i)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    function automatic void push_exp(input logic we, input logic [3:0] sel,
                                     input logic [31:0] adr, input logic [31:0] dat);
        bit legal;
        logic [2:0] sz;
        logic [1:0] off;
        xfer_t e;
        legal = 1'b1; sz = 3'd0; off = 2'd0;
        case (sel)
            4'b1111: sz = 3'd2;
            4'b0011: sz = 3'd1;
            4'b1100: begin sz = 3'd1; off = 2'd2; end
            4'b0001: off = 2'd0;
            4'b0010: off = 2'd1;
            4'b0100: off = 2'd2;
            4'b1000: off = 2'd3;
            default: legal = 1'b0;
        endcase
        e.addr = (adr & MASK) | BASE | {30'd0, off};
        e.size = sz; e.write = we; e.wdata = dat;
        e.burst = 3'b000; e.prot = 4'b0011; e.lock = 1'b0;
        if (legal) exp_q.push_back(e);
    endfunction

    // Drives one Wishbone request and plays the AHB slave; records address/data phases.
    // resp_mode: 0 OKAY, 1 two-cycle ERROR, 2 HRESP glitch during first wait only.
    task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                           input logic [31:0] dat, input int waits, input logic [31:0] rdata,
                           input int resp_mode, input int drop_at, input bit clr_with_req,
                           output int ack_cyc, output int ack_cnt);
        int phase, dcnt;
        xfer_t cur;
        phase = 0; dcnt = 0; ack_cyc = -1; ack_cnt = 0; cur = '0;
        wbs_we_i = we; wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; err_clr_i = clr_with_req;
        push_exp(we, sel, adr, dat);
        for (int n = 1; n <= waits + 8; n++) begin
            @(negedge HCLK);
            if (wbs_ack_o) begin
                ack_cnt++;
                if (ack_cyc < 0) ack_cyc = n;
            end
            if (phase == 1) begin
                HREADY = (dcnt == waits);
                HRESP  = (resp_mode == 1 && dcnt >= waits - 1) ||
                         (resp_mode == 2 && dcnt == 0 && waits > 0);
                HRDATA = HREADY ? rdata : 32'hDEAD_BEEF;
                if (HREADY) begin
                    cur.wdata = HWDATA;
                    obs_q.push_back(cur);
                    phase = 2;
                end
                dcnt++;
            end else begin
                HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hDEAD_BEEF;
                if (HTRANS == 2'b10) begin
                    cur = '{addr: HADDR, size: HSIZE, write: HWRITE, wdata: 32'd0,
                            burst: HBURST, prot: HPROT, lock: HMASTLOCK};
                    phase = 1; dcnt = 0;
                end
            end
            if (wbs_ack_o || n == drop_at) begin
                wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
            end
            if (n == 1) err_clr_i = 1'b0;
            if (ack_cyc >= 0 && n == ack_cyc + 1) break;
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
        wbs_adr_i = 0; wbs_dat_i = 0; HREADY = 1; HRDATA = 0; HRESP = 0; err_clr_i = 0;
        repeat (2) @(negedge HCLK);
        n_cmp++;
        if ({wbs_ack_o, wbs_dat_o, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, err_o, HBURST, HMASTLOCK} !== '0) begin
            n_err++;
            $display("FAIL reset_values ack=%b dat=%h haddr=%h htrans=%b hsize=%0d hwrite=%b hwdata=%h err=%b want all 0",
                     wbs_ack_o, wbs_dat_o, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, err_o);
        end
        HRESETn = 1'b1;
        @(negedge HCLK);
        n_cmp++;
        if (HTRANS !== 2'b00 || wbs_ack_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset htrans=%b ack=%b want 00/0", HTRANS, wbs_ack_o);
        end
    endtask

    task automatic test_word_write();
        int ac, an; xfer_t o, e;
        wb_xfer(1'b1, 4'hF, 32'h100, 32'hA5A5_0001, 0, 32'd0, 0, 0, 1'b0, ac, an);
        n_cmp++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_err++; $display("FAIL word_write_xfer observed=%0d expected=%0d", obs_q.size(), exp_q.size());
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin n_err++; $display("FAIL word_write_xfer got %h want %h", o, e); end
        end
        n_cmp++;
        if (ac !== 3 || an !== 1) begin n_err++; $display("FAIL word_write_ack cycle=%0d count=%0d want 3/1", ac, an); end
        n_cmp++;
        if (wbs_dat_o !== exp_rd || err_o !== 1'b0) begin
            n_err++; $display("FAIL word_write_status dat=%h err=%b want %h/0", wbs_dat_o, err_o, exp_rd);
        end
    endtask

    task automatic test_byte_read_wait();
        int ac, an; xfer_t o, e;
        wb_xfer(1'b0, 4'b0100, 32'h204, 32'd0, 2, 32'h00EE_0000, 0, 0, 1'b0, ac, an);
        exp_rd = 32'h00EE_0000;
        n_cmp++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_err++; $display("FAIL byte_read_xfer observed=%0d expected=%0d", obs_q.size(), exp_q.size());
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin n_err++; $display("FAIL byte_read_xfer got %h want %h", o, e); end
        end
        n_cmp++;
        if (ac !== 5 || an !== 1) begin n_err++; $display("FAIL byte_read_ack cycle=%0d count=%0d want 5/1", ac, an); end
        n_cmp++;
        if (wbs_dat_o !== exp_rd) begin n_err++; $display("FAIL byte_read_data got %h want %h", wbs_dat_o, exp_rd); end
    endtask

    task automatic test_ahb_error();
        int ac, an; xfer_t o, e;
        wb_xfer(1'b1, 4'hF, 32'h10, 32'h1234_5678, 1, 32'd0, 1, 0, 1'b0, ac, an);
        n_cmp++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_err++; $display("FAIL ahb_error_xfer observed=%0d expected=%0d", obs_q.size(), exp_q.size());
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin n_err++; $display("FAIL ahb_error_xfer got %h want %h", o, e); end
        end
        n_cmp++;
        if (ac !== 4 || an !== 1 || err_o !== 1'b1) begin
            n_err++; $display("FAIL ahb_error_ack cycle=%0d count=%0d err=%b want 4/1/1", ac, an, err_o);
        end
        n_cmp++;
        if (wbs_dat_o !== exp_rd) begin n_err++; $display("FAIL ahb_error_dat_hold got %h want %h", wbs_dat_o, exp_rd); end
        err_clr_i = 1'b1;
        @(negedge HCLK);
        err_clr_i = 1'b0;
        @(negedge HCLK);
        n_cmp++;
        if (err_o !== 1'b0) begin n_err++; $display("FAIL err_clear got %b want 0", err_o); end
    endtask

    task automatic test_hresp_glitch();
        int ac, an; xfer_t o, e;
        wb_xfer(1'b0, 4'b0011, 32'h40, 32'd0, 2, 32'h0000_BEEF, 2, 0, 1'b0, ac, an);
        exp_rd = 32'h0000_BEEF;
        n_cmp++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_err++; $display("FAIL glitch_xfer observed=%0d expected=%0d", obs_q.size(), exp_q.size());
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin n_err++; $display("FAIL glitch_xfer got %h want %h", o, e); end
        end
        n_cmp++;
        if (ac !== 5 || an !== 1 || err_o !== 1'b0 || wbs_dat_o !== exp_rd) begin
            n_err++; $display("FAIL glitch_result cycle=%0d count=%0d err=%b dat=%h want 5/1/0/%h",
                              ac, an, err_o, wbs_dat_o, exp_rd);
        end
    endtask

    task automatic test_illegal_sel();
        int ac, an;
        wb_xfer(1'b0, 4'b0101, 32'h80, 32'd0, 0, 32'd0, 0, 0, 1'b0, ac, an);
        exp_rd = 32'd0;
        n_cmp++;
        if (obs_q.size() !== 0) begin n_err++; $display("FAIL illegal_no_ahb transfers=%0d want 0", obs_q.size()); obs_q.delete(); end
        n_cmp++;
        if (ac !== 1 || an !== 1 || wbs_dat_o !== 32'd0 || err_o !== 1'b1) begin
            n_err++; $display("FAIL illegal_result cycle=%0d count=%0d dat=%h err=%b want 1/1/0/1", ac, an, wbs_dat_o, err_o);
        end
        err_clr_i = 1'b1;
        @(negedge HCLK);
        err_clr_i = 1'b0;
        n_cmp++;
        if (err_o !== 1'b0) begin n_err++; $display("FAIL illegal_err_clear got %b want 0", err_o); end
    endtask

    task automatic test_set_beats_clear();
        int ac, an;
        wb_xfer(1'b1, 4'b0000, 32'h84, 32'd0, 0, 32'd0, 0, 0, 1'b1, ac, an);
        n_cmp++;
        if (err_o !== 1'b1 || ac !== 1) begin
            n_err++; $display("FAIL set_beats_clear err=%b ack_cycle=%0d want 1/1", err_o, ac);
        end
        err_clr_i = 1'b1;
        @(negedge HCLK);
        err_clr_i = 1'b0;
    endtask

    task automatic test_abort();
        int ac, an; xfer_t o, e;
        wb_xfer(1'b1, 4'hF, 32'h300, 32'hCAFE_F00D, 0, 32'd0, 0, 1, 1'b0, ac, an);
        n_cmp++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_err++; $display("FAIL abort_xfer observed=%0d expected=%0d", obs_q.size(), exp_q.size());
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin n_err++; $display("FAIL abort_xfer got %h want %h", o, e); end
        end
        n_cmp++;
        if (an !== 0 || HTRANS !== 2'b00) begin n_err++; $display("FAIL abort_no_ack count=%0d htrans=%b want 0/00", an, HTRANS); end
    endtask

    task automatic test_addr_translation();
        int ac, an; xfer_t o, e;
        wb_xfer(1'b0, 4'b1100, 32'hFF12_3458, 32'd0, 0, 32'h5A5A_0000, 0, 0, 1'b0, ac, an);
        exp_rd = 32'h5A5A_0000;
        n_cmp++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_err++; $display("FAIL xlate_xfer observed=%0d expected=%0d", obs_q.size(), exp_q.size());
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o.addr !== 32'h2012_345A || o !== e) begin n_err++; $display("FAIL xlate_xfer got %h want %h", o, e); end
        end
        n_cmp++;
        if (ac !== 3 || wbs_dat_o !== exp_rd) begin n_err++; $display("FAIL xlate_ack cycle=%0d dat=%h want 3/%h", ac, wbs_dat_o, exp_rd); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  sels [3] = '{4'b0001, 4'b0010, 4'b1000};
        logic [31:0] adrs [3] = '{32'h700, 32'h704, 32'h70C};
        logic [31:0] rds  [3] = '{32'h0000_0011, 32'h0000_2200, 32'h4400_0000};
        int          wts  [3] = '{0, 1, 0};
        int ac, an; xfer_t o, e;
        for (int i = 0; i < 3; i++) begin
            wb_xfer(1'b0, sels[i], adrs[i], 32'd0, wts[i], rds[i], 0, 0, 1'b0, ac, an);
            exp_rd = rds[i];
            n_cmp++;
            if (obs_q.size() == 0 || exp_q.size() == 0) begin
                n_err++; $display("FAIL b2b_xfer[%0d] observed=%0d expected=%0d", i, obs_q.size(), exp_q.size());
            end else begin
                o = obs_q.pop_front(); e = exp_q.pop_front();
                if (o !== e) begin n_err++; $display("FAIL b2b_xfer[%0d] got %h want %h", i, o, e); end
            end
            n_cmp++;
            if (ac !== 3 + wts[i] || an !== 1 || wbs_dat_o !== exp_rd) begin
                n_err++; $display("FAIL b2b_result[%0d] cycle=%0d count=%0d dat=%h want %0d/1/%h",
                                  i, ac, an, wbs_dat_o, 3 + wts[i], exp_rd);
            end
        end
    endtask

    task automatic test_reset_mid();
        int ac, an; bit seen; xfer_t o, e, cur;
        seen = 0; cur = '0;
        wbs_we_i = 1'b0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h500; wbs_dat_i = 32'd0;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        push_exp(1'b0, 4'hF, 32'h500, 32'd0);
        for (int n = 1; n <= 10; n++) begin
            @(negedge HCLK);
            HRESP = 1'b0;
            if (seen) begin
                HREADY = 1'b0;
                #1 HRESETn = 1'b0;
                #1;
                n_cmp++;
                if ({wbs_ack_o, wbs_dat_o, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, err_o} !== '0) begin
                    n_err++;
                    $display("FAIL reset_mid_values ack=%b dat=%h haddr=%h htrans=%b hsize=%0d hwrite=%b err=%b want all 0",
                             wbs_ack_o, wbs_dat_o, HADDR, HTRANS, HSIZE, HWRITE, err_o);
                end
                break;
            end
            if (HTRANS == 2'b10) begin
                cur = '{addr: HADDR, size: HSIZE, write: HWRITE, wdata: HWDATA,
                        burst: HBURST, prot: HPROT, lock: HMASTLOCK};
                obs_q.push_back(cur);
                seen = 1; HREADY = 1'b1;
            end
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL reset_mid_timeout no address phase within 10 cycles"); end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1; HREADY = 1'b1;
        exp_rd = 32'd0;
        n_cmp++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_err++; $display("FAIL reset_mid_xfer observed=%0d expected=%0d", obs_q.size(), exp_q.size());
            obs_q.delete(); exp_q.delete();
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin n_err++; $display("FAIL reset_mid_xfer got %h want %h", o, e); end
        end
        wb_xfer(1'b1, 4'hF, 32'h600, 32'h1111_2222, 0, 32'd0, 0, 0, 1'b0, ac, an);
        n_cmp++;
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            n_err++; $display("FAIL post_reset_xfer observed=%0d expected=%0d", obs_q.size(), exp_q.size());
        end else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            if (o !== e) begin n_err++; $display("FAIL post_reset_xfer got %h want %h", o, e); end
        end
        n_cmp++;
        if (ac !== 3 || an !== 1 || wbs_dat_o !== exp_rd) begin
            n_err++; $display("FAIL post_reset_ack cycle=%0d count=%0d dat=%h want 3/1/%h", ac, an, wbs_dat_o, exp_rd);
        end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_byte_read_wait();
        test_ahb_error();
        test_hresp_glitch();
        test_illegal_sel();
        test_set_beats_clear();
        test_abort();
        test_addr_translation();
        test_back_to_back();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() !== 0 || obs_q.size() !== 0) begin
            n_err++; $display("FAIL scoreboard_drain expected_left=%0d observed_left=%0d want 0/0", exp_q.size(), obs_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
